// File: rtl/pu_sched_pkg.sv
// Shared types and constants for the PU job scheduler: FSM state, default
// geometry, operand width and the field layout of a vector-memory word.
package pu_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int AW_DEF     = 4;
  localparam int PU_LAT_DEF = 3;

  localparam int OPW     = 5;
  localparam int LANES   = 4;
  localparam int VEC_W   = LANES * OPW;
  localparam int RDATA_W = 2 * VEC_W;

  // Word layout is {x4,x3,x2,x1,w4,w3,w2,w1}; lane i sits at <base> + i*OPW.
  localparam int W1_LSB = 0;
  localparam int X1_LSB = VEC_W;

  function automatic logic [VEC_W-1:0] x_field(input logic [RDATA_W-1:0] rd);
    return rd[X1_LSB +: VEC_W];
  endfunction

  function automatic logic [VEC_W-1:0] w_field(input logic [RDATA_W-1:0] rd);
    return rd[W1_LSB +: VEC_W];
  endfunction

endpackage

// File: rtl/pu_sched_if.sv
// Handshake and data bundle between the job scheduler and its environment
// (vector memory, PU and result store).
interface pu_sched_if #(
  parameter int AW = pu_sched_pkg::AW_DEF
);
  import pu_sched_pkg::*;

  logic               start;
  logic               abort;
  logic [AW:0]        num_vec;
  logic               mem_re;
  logic [AW-1:0]      mem_addr;
  logic [RDATA_W-1:0] mem_rdata;
  logic [VEC_W-1:0]   pu_x;
  logic [VEC_W-1:0]   pu_w;
  logic [OPW-1:0]     pu_out;
  logic               res_we;
  logic [AW-1:0]      res_addr;
  logic [OPW-1:0]     res_data;
  logic               busy;
  logic               done;

  modport master (
    output start, abort, num_vec, mem_rdata, pu_out,
    input  mem_re, mem_addr, pu_x, pu_w, res_we, res_addr, res_data, busy, done
  );

  modport slave (
    input  start, abort, num_vec, mem_rdata, pu_out,
    output mem_re, mem_addr, pu_x, pu_w, res_we, res_addr, res_data, busy, done
  );

endinterface

// File: rtl/pu_sched_valid_pipe.sv
// Valid/address delay line: tags every vector read with its address so the
// matching PU result can be written back DEPTH cycles after the read strobe.
module pu_valid_pipe #(
  parameter int DEPTH = 4,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [AW-1:0]    in_addr,
  output logic [DEPTH-1:0] valid,
  output logic [AW-1:0]    out_addr
);

  logic [DEPTH-1:0]         valid_q, valid_d;
  logic [DEPTH-1:0][AW-1:0] addr_q,  addr_d;

  // Shift one stage per cycle; a flush empties every stage at once.
  always_comb begin
    valid_d = '0;
    addr_d  = '0;
    if (flush) begin
      valid_d = '0;
      addr_d  = '0;
    end else if (in_valid) begin
      valid_d = {valid_q[DEPTH-2:0], 1'b1};
      addr_d  = {addr_q[DEPTH-2:0], in_addr};
    end else begin
      valid_d = {valid_q[DEPTH-2:0], 1'b0};
      addr_d  = {addr_q[DEPTH-2:0], {AW{1'b0}}};
    end
  end

  // Stage registers, cleared asynchronously so in-flight tags vanish on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid    = valid_q;
  assign out_addr = addr_q[DEPTH-1];

endmodule

// File: rtl/pu_sched.sv
// Job scheduler for a 4-lane dot-product PU: streams num_vec vectors from the
// vector memory into the PU and writes each result back at its source address.
module pu_sched
  import pu_sched_pkg::*;
#(
  parameter int AW     = AW_DEF,
  parameter int PU_LAT = PU_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  pu_sched_if.slave bus
);

  localparam int          DEPTH   = PU_LAT + 1;
  localparam logic [AW:0] MAX_VEC = (AW+1)'(1) << AW;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q,   cnt_d;
  logic [AW:0]   num_q,   num_d;
  logic          mem_re_q, mem_re_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic [AW:0]      num_clamp_s;
  logic             abort_s;
  logic             last_s;
  logic             drain_empty_s;
  logic [DEPTH-1:0] stg_valid_s;
  logic [AW-1:0]    tag_addr_s;

  // Job-control qualifiers derived from the current state.
  always_comb begin
    num_clamp_s = bus.num_vec;
    if (bus.num_vec > MAX_VEC) begin
      num_clamp_s = MAX_VEC;
    end else begin
      num_clamp_s = bus.num_vec;
    end
    abort_s = bus.abort && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    // Widened compare so a full 2^AW job ends on the last address without wrapping.
    last_s        = (({1'b0, cnt_q} + (AW+1)'(1)) == num_q);
    drain_empty_s = ~|stg_valid_s[DEPTH-2:0];
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          num_d = num_clamp_s;
          cnt_d = '0;
          if (num_clamp_s == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (last_s) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          state_d = ST_RUN;
          cnt_d   = cnt_q + AW'(1);
        end
      end
      ST_DRAIN: begin
        if (abort_s) begin
          state_d = ST_IDLE;
        end else if (drain_empty_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Registered status outputs decoded from the state being entered.
  always_comb begin
    mem_re_d = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      ST_RUN: begin
        mem_re_d = 1'b1;
        busy_d   = 1'b1;
      end
      ST_DRAIN: begin
        busy_d = 1'b1;
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        mem_re_d = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
      end
    endcase
  end

  // State, counter, latched job length and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      num_q    <= '0;
      mem_re_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      num_q    <= num_d;
      mem_re_q <= mem_re_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  pu_valid_pipe #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_valid_pipe (
    .clk      (clk),
    .rst      (rst),
    .flush    (abort_s),
    .in_valid (mem_re_q),
    .in_addr  (cnt_q),
    .valid    (stg_valid_s),
    .out_addr (tag_addr_s)
  );

  // Operand and result gating: nothing reaches the PU or result store untagged.
  always_comb begin
    if (stg_valid_s[0]) begin
      bus.pu_x = x_field(bus.mem_rdata);
      bus.pu_w = w_field(bus.mem_rdata);
    end else begin
      bus.pu_x = '0;
      bus.pu_w = '0;
    end
    if (stg_valid_s[DEPTH-1]) begin
      bus.res_we   = 1'b1;
      bus.res_addr = tag_addr_s;
      bus.res_data = bus.pu_out;
    end else begin
      bus.res_we   = 1'b0;
      bus.res_addr = '0;
      bus.res_data = '0;
    end
  end

  // cnt_q is cleared on every exit from RUN, so it reads 0 whenever mem_re is low.
  assign bus.mem_re   = mem_re_q;
  assign bus.mem_addr = cnt_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_pu_sched.sv
// Randomized bench for pu_sched: vector memory and 3-stage ReLU PU models
// drive the DUT; expected per-cycle outputs come from the job timing rules.
module tb_pu_sched;
  import pu_sched_pkg::*;

  localparam int AW      = 4;
  localparam int PU_LAT  = 3;
  localparam int NV_MAX  = 1 << AW;
  localparam int CYC_MAX = 8192;
  localparam logic [RDATA_W-1:0] VEC_POS = {5'd4, 5'd3, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
  localparam logic [RDATA_W-1:0] VEC_NEG = {5'd4, 5'd3, 5'd2, 5'd1, 5'h1f, 5'h1f, 5'h1f, 5'h1f};

  logic clk;
  logic rst;
  pu_sched_if #(.AW(AW)) bus ();

  pu_sched #(.AW(AW), .PU_LAT(PU_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [RDATA_W-1:0] mem [NV_MAX];
  logic [OPW-1:0]     pp0, pp1, pp2;
  int cyc;
  int idle_from;
  int n_vec;
  int n_err;

  bit exp_re   [CYC_MAX];
  int exp_addr [CYC_MAX];
  bit exp_s1   [CYC_MAX];
  int exp_s1a  [CYC_MAX];
  bit exp_we   [CYC_MAX];
  int exp_wa   [CYC_MAX];
  bit exp_busy [CYC_MAX];
  bit exp_done [CYC_MAX];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Reference PU: signed 5-bit lanes, dot product, ReLU saturated to 5 bits.
  function automatic logic [OPW-1:0] pu_f(input logic [VEC_W-1:0] x, input logic [VEC_W-1:0] w);
    int acc;
    int xi;
    int wi;
    acc = 0;
    for (int i = 0; i < LANES; i++) begin
      xi = $signed(x[i*OPW +: OPW]);
      wi = $signed(w[i*OPW +: OPW]);
      acc += xi * wi;
    end
    if (acc < 0) return '0;
    if (acc > 31) return 5'd31;
    return acc[OPW-1:0];
  endfunction

  // Expected activity of a job requested in cycle s (ab = abort cycle offset, -1 none).
  task automatic plan(input int s, input int n_raw, input int ab);
    int n;
    int cut;
    int r;
    bit ab_eff;
    if (ab == 0) return;
    n = (n_raw > NV_MAX) ? NV_MAX : n_raw;
    if (n == 0) begin
      exp_done[s+1] = 1'b1;
      idle_from = s + 2;
      return;
    end
    ab_eff = (ab >= 1) && (ab <= n + 4);
    cut = ab_eff ? s + ab : s + n + 4;
    for (int c = s + 1; c <= cut; c++) exp_busy[c] = 1'b1;
    for (int i = 0; i < n; i++) begin
      r = s + 1 + i;
      if (r <= cut)     begin exp_re[r]   = 1'b1; exp_addr[r]  = i; end
      if (r < cut)      begin exp_s1[r+1] = 1'b1; exp_s1a[r+1] = i; end
      if (r + 4 <= cut) begin exp_we[r+4] = 1'b1; exp_wa[r+4]  = i; end
    end
    if (!ab_eff) exp_done[s+n+5] = 1'b1;
    idle_from = ab_eff ? s + ab + 1 : s + n + 6;
  endtask

  task automatic check_cycle();
    logic [RDATA_W-1:0] v1;
    logic [RDATA_W-1:0] vw;
    v1 = exp_s1[cyc] ? mem[exp_s1a[cyc]] : '0;
    vw = mem[exp_wa[cyc]];
    chk("mem_re",   bus.mem_re,   exp_re[cyc]);
    chk("mem_addr", bus.mem_addr, exp_re[cyc] ? exp_addr[cyc] : 0);
    chk("pu_x",     bus.pu_x,     x_field(v1));
    chk("pu_w",     bus.pu_w,     w_field(v1));
    chk("res_we",   bus.res_we,   exp_we[cyc]);
    chk("res_addr", bus.res_addr, exp_we[cyc] ? exp_wa[cyc] : 0);
    chk("res_data", bus.res_data, exp_we[cyc] ? pu_f(x_field(vw), w_field(vw)) : '0);
    chk("busy",     bus.busy,     exp_busy[cyc]);
    chk("done",     bus.done,     exp_done[cyc]);
  endtask

  // Advance one clock: feed memory data and PU result for the new cycle, then check it.
  task automatic tick();
    logic           re_s;
    logic [AW-1:0]  a_s;
    logic [OPW-1:0] f_s;
    re_s = bus.mem_re;
    a_s  = bus.mem_addr;
    f_s  = pu_f(bus.pu_x, bus.pu_w);
    @(posedge clk);
    #1;
    cyc++;
    bus.mem_rdata = re_s ? mem[a_s] : {8'($urandom), 32'($urandom)};
    pp2 = pp1;
    pp1 = pp0;
    pp0 = f_s;
    bus.pu_out = pp2;
    #1;
    if (cyc >= CYC_MAX - 64) begin
      $display("FAIL cycle_budget cycle %0d: got %0d, expected below %0d", cyc, cyc, CYC_MAX - 64);
      $fatal(1, "cycle budget exhausted");
    end
    check_cycle();
  endtask

  // stray_rel: -1 none, -2 random cycle while the job is not idle.
  task automatic run_job(input int n_raw, input int ab_rel, input int stray_rel, input bit dot_chk);
    int s;
    int st;
    s = cyc;
    for (int i = 0; i < NV_MAX; i++) mem[i] = {8'($urandom), 32'($urandom)};
    if (dot_chk) begin
      mem[0] = VEC_POS;
      mem[1] = VEC_NEG;
    end
    bus.num_vec = (AW+1)'(n_raw);
    bus.start   = 1'b1;
    bus.abort   = (ab_rel == 0);
    plan(s, n_raw, ab_rel);
    st = stray_rel;
    if (st == -2) st = (idle_from > s + 1) ? $urandom_range(1, idle_from - s - 1) : -1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    while (cyc < idle_from) begin
      bus.start = (cyc - s == st);
      bus.abort = (cyc - s == ab_rel);
      if (bus.start) bus.num_vec = (AW+1)'($urandom);
      if (dot_chk && cyc == s + 5) chk("dot_pos", bus.res_data, 5'd10);
      if (dot_chk && cyc == s + 6) chk("relu_neg", bus.res_data, 5'd0);
      tick();
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask

  task automatic reset_mid_job();
    int s;
    s = cyc;
    for (int i = 0; i < NV_MAX; i++) mem[i] = {8'($urandom), 32'($urandom)};
    bus.num_vec = (AW+1)'(5);
    bus.start   = 1'b1;
    plan(s, 5, -1);
    tick();
    bus.start = 1'b0;
    while (cyc < s + 4) tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_re",   bus.mem_re,   1'b0);
    chk("rst_mem_addr", bus.mem_addr, '0);
    chk("rst_pu_x",     bus.pu_x,     '0);
    chk("rst_pu_w",     bus.pu_w,     '0);
    chk("rst_res_we",   bus.res_we,   1'b0);
    chk("rst_res_addr", bus.res_addr, '0);
    chk("rst_res_data", bus.res_data, '0);
    chk("rst_busy",     bus.busy,     1'b0);
    chk("rst_done",     bus.done,     1'b0);
    for (int c = cyc + 1; c < CYC_MAX; c++) begin
      exp_re[c] = 1'b0; exp_s1[c] = 1'b0; exp_we[c] = 1'b0;
      exp_busy[c] = 1'b0; exp_done[c] = 1'b0;
    end
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    idle_from = cyc;
    run_job(2, -1, -1, 1'b0);
  endtask

  initial begin
    int n;
    int ab;
    int st;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.num_vec = '0;
    bus.mem_rdata = '0;
    bus.pu_out = '0;
    pp0 = '0; pp1 = '0; pp2 = '0;
    cyc = 0; idle_from = 0; n_vec = 0; n_err = 0;
    for (int i = 0; i < NV_MAX; i++) mem[i] = '0;
    #2;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    idle_from = cyc;

    run_job(3, -1, -1, 1'b1);
    run_job(0, -1, -1, 1'b0);
    run_job(16, 6, -1, 1'b0);
    run_job(4, -1, 2, 1'b0);
    run_job(31, -1, -1, 1'b0);
    run_job(5, 0, -1, 1'b0);
    run_job(3, 8, -1, 1'b0);
    reset_mid_job();

    for (int j = 0; j < 40; j++) begin
      repeat ($urandom_range(0, 3)) begin
        bus.abort = ($urandom_range(0, 3) == 0);
        tick();
      end
      bus.abort = 1'b0;
      n  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(17, 31)) : int'($urandom_range(0, 16));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, n + 5)) : -1;
      st = ($urandom_range(0, 2) == 0) ? -2 : -1;
      run_job(n, ab, st, 1'b0);
    end
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
